prog_clk_div: RTL and testbench
===============================

PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter CNT_W, default 26: counter and divide-value width in bits.
REQ-003 Parameter DEF_DIV, default 50000000: divide value loaded into every channel at reset; SHALL fit in CNT_W bits.
REQ-004 Local CH_W = max(1, clog2(NUM_CH)).
REQ-005 top_clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 en  in  NUM_CH  per-channel count enable.
REQ-008 cfg_valid  in  1  divide-value write request.
REQ-009 cfg_ch  in  CH_W  target channel of the write.
REQ-010 cfg_div  in  CNT_W  new divide value.
REQ-011 cfg_ready  out  1  write accepted when cfg_valid and cfg_ready are both high on a rising edge.
REQ-012 clk_out  out  NUM_CH  divided clock per channel, registered.
REQ-013 tick  out  NUM_CH  one-cycle pulse per channel on each clk_out toggle, registered.

Function
REQ-014 Each channel has a counter cnt[CNT_W], active divide value div, pending value pend and pending flag pflag.
REQ-015 en high and cnt < div: cnt increments by 1; clk_out holds; tick 0.
REQ-016 en high and cnt >= div (terminal event): cnt becomes 0, clk_out inverts, tick 1 for that cycle.
REQ-017 Half-period is div+1 top_clk cycles; full period 2*(div+1); div=0 toggles every cycle with tick held high.
REQ-018 en low: cnt and clk_out hold, tick 0.
REQ-019 cfg_ready is combinational: low when pflag[cfg_ch] is set, otherwise high.
REQ-020 Accepted write with cfg_ch < NUM_CH stores cfg_div into pend and sets pflag for that channel.
REQ-021 Accepted write with cfg_ch >= NUM_CH is discarded without side effects.
REQ-022 pflag set and terminal event: div takes pend, pflag clears, same edge; the new div governs from the next count.
REQ-023 pflag set and en low: div takes pend, cnt becomes 0, pflag clears, clk_out holds.
REQ-024 Write accepted on the same edge as a terminal event of that channel: pend is stored and applied at the following terminal event, not the current one.
REQ-025 A write to a channel with pflag set stalls through cfg_ready low until the pending value is applied; no write is ever lost or overwritten.
REQ-026 Channels are fully independent; a write to one channel never alters another channel's cnt, div or outputs.

Reset
REQ-027 rst high: cnt=0, clk_out=0, tick=0, div=DEF_DIV, pend=0, pflag=0 for all channels, regardless of state.
REQ-028 cfg_ready is high during and immediately after reset; a pending write is discarded by reset.
REQ-029 First terminal event after rst release with en high occurs on the (DEF_DIV+1)th enabled edge.

Configuration
REQ-030 Macro PROG_CLK_DIV_TICK_EN defined: tick behaves per REQ-016 to REQ-018.
REQ-031 PROG_CLK_DIV_TICK_EN undefined: tick port is still present, tied to all zeros, and no tick registers are built; clk_out behaviour is unchanged.

Verification (NUM_CH=2, CNT_W=8, DEF_DIV=3, macro defined)
REQ-032 Release rst, en=2'b11 -> clk_out[0] and clk_out[1] rise on edge 4 and toggle every 4 edges after; tick pulses on edges 4, 8, 12.
REQ-033 Mid-period write ch0 div=1 -> cfg_ready low until the next ch0 toggle; afterwards ch0 toggles every 2 cycles while ch1 keeps toggling every 4.
REQ-034 Back-to-back writes ch0 div=5 then div=0 -> second write is held by cfg_ready=0; div=5 is applied, then div=0 is applied 6 cycles later; ch0 then toggles every cycle with tick constantly high.
REQ-035 en[1]=0 at cnt=2 -> ch1 holds for 10 cycles; a write ch1 div=7 while disabled applies next cycle with cnt=0; re-enable -> first toggle after 8 edges.
REQ-036 Write cfg_ch=3 div=9 -> accepted (cfg_ready=1), both channels unaffected.
REQ-037 rst asserted for 1 cycle with ch0 pending -> all outputs 0, div=3 on both channels, cfg_ready=1; repeat REQ-032 timing.

Source files
------------

// File: rtl/prog_clk_div.sv
// -----------------------------------------------------------------------------
// prog_clk_div
//
// Bank of NUM_CH independent programmable clock dividers running from a single
// clock. Each channel counts enabled top_clk edges; when its counter reaches the
// active divide value the channel's divided clock inverts and the counter
// restarts, giving a half-period of (div + 1) enabled edges.
//
// Divide values are changed through a shared valid/ready write port. A write
// parks the new value in a per-channel pending register; it becomes active at
// the channel's next terminal event (or on the next edge if the channel is
// disabled). While a value is pending for the addressed channel the port
// back-pressures, so no write is ever overwritten. Writes addressed to a
// channel index that does not exist are accepted and dropped.
//
// Optional feature (compile-time macro):
//   PROG_CLK_DIV_TICK_EN  defined   -> tick[n] pulses for one cycle whenever
//                                       clk_out[n] toggles (registered).
//                         undefined -> tick is tied to zero, no tick registers.
//
// Parameters:
//   NUM_CH   number of divider channels (1..16)
//   CNT_W    counter / divide-value width
//   DEF_DIV  divide value loaded into every channel at reset (fits in CNT_W)
//
// Ports:
//   top_clk    in   1        sole clock, rising edge
//   rst        in   1        synchronous active-high reset
//   en         in   NUM_CH   per-channel count enable
//   cfg_valid  in   1        divide-value write request
//   cfg_ch     in   CH_W     target channel of the write
//   cfg_div    in   CNT_W    new divide value
//   cfg_ready  out  1        write accepted when cfg_valid & cfg_ready (comb.)
//   clk_out    out  NUM_CH   divided clock per channel (registered)
//   tick       out  NUM_CH   one-cycle pulse on each clk_out toggle (registered)
// -----------------------------------------------------------------------------
module prog_clk_div #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 26,
    parameter int DEF_DIV = 50000000,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              top_clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    // Every code cfg_ch can express; codes at or above NUM_CH have no channel.
    localparam int CH_SPAN = 1 << CH_W;
    localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);

    logic [NUM_CH-1:0]  w_pflag;      // pending flag of each real channel
    logic [CH_SPAN-1:0] w_pflag_ext;  // pending flags padded to the full code space
    logic               w_cfg_fire;   // a write is accepted on this edge

    genvar gi;

    // Nonexistent channels never have anything pending, so the port is always
    // ready for them and the write simply matches no channel below.
    generate
        for (gi = 0; gi < CH_SPAN; gi++) begin : g_pf_ext
            if (gi < NUM_CH) begin : g_real
                assign w_pflag_ext[gi] = w_pflag[gi];
            end else begin : g_pad
                assign w_pflag_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign cfg_ready  = ~w_pflag_ext[cfg_ch];
    assign w_cfg_fire = cfg_valid & cfg_ready;

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_div;
            logic [CNT_W-1:0] r_pend;
            logic             r_pflag;
            logic             r_clk;

            logic [CNT_W-1:0] w_cnt_next;
            logic [CNT_W-1:0] w_div_next;
            logic [CNT_W-1:0] w_pend_next;
            logic             w_pflag_next;
            logic             w_clk_next;
            logic             w_term;
            logic             w_wr;
            logic             w_apply;

            // The counter never exceeds div (div only changes while the counter
            // is being cleared), so ">=" is just a robust form of "==".
            assign w_term  = en[gi] & (r_cnt >= r_div);
            assign w_wr    = w_cfg_fire & (cfg_ch == CH_W'(gi));
            // A pending value is committed at a terminal event, or immediately
            // when the channel is idle so a disabled channel does not block
            // the write port forever.
            assign w_apply = r_pflag & (w_term | ~en[gi]);

            always_comb begin
                w_cnt_next   = r_cnt;
                w_clk_next   = r_clk;
                w_div_next   = r_div;
                w_pend_next  = r_pend;
                w_pflag_next = r_pflag;

                if (en[gi]) begin
                    if (w_term) begin
                        w_cnt_next = '0;
                        w_clk_next = ~r_clk;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end else if (r_pflag) begin
                    // Idle apply restarts the period so the new value is
                    // honoured in full once counting resumes.
                    w_cnt_next = '0;
                end

                if (w_apply) begin
                    w_div_next   = r_pend;
                    w_pflag_next = 1'b0;
                end

                // A write can only land while nothing is pending (cfg_ready),
                // so it never collides with w_apply. A write coinciding with a
                // terminal event is therefore held for the following one.
                if (w_wr) begin
                    w_pend_next  = cfg_div;
                    w_pflag_next = 1'b1;
                end
            end

            always_ff @(posedge top_clk) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_div   <= DEF_DIV_V;
                    r_pend  <= '0;
                    r_pflag <= 1'b0;
                    r_clk   <= 1'b0;
                end else begin
                    r_cnt   <= w_cnt_next;
                    r_div   <= w_div_next;
                    r_pend  <= w_pend_next;
                    r_pflag <= w_pflag_next;
                    r_clk   <= w_clk_next;
                end
            end

            assign w_pflag[gi] = r_pflag;
            assign clk_out[gi] = r_clk;

`ifdef PROG_CLK_DIV_TICK_EN
            logic r_tick;

            always_ff @(posedge top_clk) begin
                if (rst) begin
                    r_tick <= 1'b0;
                end else begin
                    r_tick <= w_term;
                end
            end

            assign tick[gi] = r_tick;
`else
            assign tick[gi] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_prog_clk_div.sv
// -----------------------------------------------------------------------------
// tb_prog_clk_div
//
// Bench for prog_clk_div. Instance u_dut_a uses NUM_CH=2, CNT_W=8, DEF_DIV=3.
// Instance u_dut_b uses NUM_CH=3 so that cfg_ch has a code (3) with no channel
// behind it. A countdown model (edges remaining until the next toggle) predicts
// clk_out / tick / cfg_ready of both instances and is compared every cycle;
// directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_prog_clk_div;

    localparam int NA = 2;
    localparam int NB = 3;
    localparam int CW = 8;
    localparam int DD = 3;
    localparam int NT = NA + NB;   // model channels: 0..1 -> a, 2..4 -> b

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [NA-1:0] en_a;
    logic          cfg_valid_a;
    logic [0:0]    cfg_ch_a;
    logic [CW-1:0] cfg_div_a;
    logic          cfg_ready_a;
    logic [NA-1:0] clk_out_a;
    logic [NA-1:0] tick_a;

    logic [NB-1:0] en_b;
    logic          cfg_valid_b;
    logic [1:0]    cfg_ch_b;
    logic [CW-1:0] cfg_div_b;
    logic          cfg_ready_b;
    logic [NB-1:0] clk_out_b;
    logic [NB-1:0] tick_b;

    prog_clk_div #(.NUM_CH(NA), .CNT_W(CW), .DEF_DIV(DD)) u_dut_a (
        .top_clk   (clk),
        .rst       (rst),
        .en        (en_a),
        .cfg_valid (cfg_valid_a),
        .cfg_ch    (cfg_ch_a),
        .cfg_div   (cfg_div_a),
        .cfg_ready (cfg_ready_a),
        .clk_out   (clk_out_a),
        .tick      (tick_a)
    );

    prog_clk_div #(.NUM_CH(NB), .CNT_W(CW), .DEF_DIV(DD)) u_dut_b (
        .top_clk   (clk),
        .rst       (rst),
        .en        (en_b),
        .cfg_valid (cfg_valid_b),
        .cfg_ch    (cfg_ch_b),
        .cfg_div   (cfg_div_b),
        .cfg_ready (cfg_ready_b),
        .clk_out   (clk_out_b),
        .tick      (tick_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected tick value depending on whether the tick feature is compiled in.
    function automatic logic [31:0] tk(input logic [31:0] v);
`ifdef PROG_CLK_DIV_TICK_EN
        return v;
`else
        return 32'(v & 32'h0);
`endif
    endfunction

    // ------------------------------------------------------------------ model
    int m_left [NT];   // enabled edges remaining until the next toggle
    int m_div  [NT];
    int m_pend [NT];
    bit m_pf   [NT];
    bit m_clk  [NT];
    bit m_tick [NT];
    bit model_valid = 1'b0;

    function automatic bit ready_a_m();
        return !m_pf[int'(cfg_ch_a)];
    endfunction

    function automatic bit ready_b_m();
        if (int'(cfg_ch_b) >= NB) return 1'b1;
        return !m_pf[NA + int'(cfg_ch_b)];
    endfunction

    task automatic step(input int g, input bit e, input bit acc, input int d);
        m_tick[g] = 1'b0;
        if (e) begin
            if (m_left[g] == 1) begin
                m_clk[g]  = !m_clk[g];
                m_tick[g] = 1'b1;
                if (m_pf[g]) begin
                    m_div[g] = m_pend[g];
                    m_pf[g]  = 1'b0;
                end
                m_left[g] = m_div[g] + 1;
            end else begin
                m_left[g] = m_left[g] - 1;
            end
        end else if (m_pf[g]) begin
            m_div[g]  = m_pend[g];
            m_pf[g]   = 1'b0;
            m_left[g] = m_div[g] + 1;
        end
        if (acc) begin
            m_pend[g] = d;
            m_pf[g]   = 1'b1;
        end
    endtask

    always @(posedge clk) begin : model
        bit acc_a;
        bit acc_b;
        if (rst) begin
            for (int g = 0; g < NT; g++) begin
                m_left[g] = DD + 1;
                m_div[g]  = DD;
                m_pend[g] = 0;
                m_pf[g]   = 1'b0;
                m_clk[g]  = 1'b0;
                m_tick[g] = 1'b0;
            end
            model_valid = 1'b1;
        end else begin
            acc_a = cfg_valid_a && ready_a_m();
            acc_b = cfg_valid_b && ready_b_m();
            for (int i = 0; i < NA; i++)
                step(i, en_a[i], acc_a && (int'(cfg_ch_a) == i), int'(cfg_div_a));
            for (int i = 0; i < NB; i++)
                step(NA + i, en_b[i], acc_b && (int'(cfg_ch_b) == i), int'(cfg_div_b));
        end
    end

    // --------------------------------------------------------- compare process
    always @(negedge clk) begin : cmp
        logic [NA-1:0] ea_c;
        logic [NA-1:0] ea_t;
        logic [NB-1:0] eb_c;
        logic [NB-1:0] eb_t;
        #1;
        if (model_valid) begin
            for (int i = 0; i < NA; i++) begin
                ea_c[i] = m_clk[i];
                ea_t[i] = m_tick[i];
            end
            for (int i = 0; i < NB; i++) begin
                eb_c[i] = m_clk[NA + i];
                eb_t[i] = m_tick[NA + i];
            end
            check("model_a_clk_out", 32'(clk_out_a), 32'(ea_c));
            check("model_a_tick", 32'(tick_a), tk(32'(ea_t)));
            check("model_a_cfg_ready", 32'(cfg_ready_a), 32'(ready_a_m()));
            check("model_b_clk_out", 32'(clk_out_b), 32'(eb_c));
            check("model_b_tick", 32'(tick_b), tk(32'(eb_t)));
            check("model_b_cfg_ready", 32'(cfg_ready_b), 32'(ready_b_m()));
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic wait_e(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        int k;
        bit sv_clk1;

        rst = 1'b1;
        en_a = '0;  cfg_valid_a = 1'b0; cfg_ch_a = '0; cfg_div_a = '0;
        en_b = '0;  cfg_valid_b = 1'b0; cfg_ch_b = '0; cfg_div_b = '0;
        wait_e(3);
        check("rst_clk_out", 32'(clk_out_a), 32'h0);
        check("rst_tick", 32'(tick_a), 32'h0);
        check("rst_ready", 32'(cfg_ready_a), 32'h1);

        // Default timing: toggle on edges 4, 8, 12.
        rst = 1'b0; en_a = 2'b11; en_b = 3'b111;
        wait_e(3);  check("e3_clk_out", 32'(clk_out_a), 32'h0);
        wait_e(1);  check("e4_clk_out", 32'(clk_out_a), 32'h3);
                    check("e4_tick", 32'(tick_a), tk(32'h3));
        wait_e(1);  check("e5_tick", 32'(tick_a), 32'h0);
        wait_e(3);  check("e8_clk_out", 32'(clk_out_a), 32'h0);
                    check("e8_tick", 32'(tick_a), tk(32'h3));
        wait_e(4);  check("e12_clk_out", 32'(clk_out_a), 32'h3);

        // Mid-period write ch0 div=1.
        wait_e(1);
        cfg_valid_a = 1'b1; cfg_ch_a = 1'b0; cfg_div_a = 8'd1;
        #1 check("wr1_ready", 32'(cfg_ready_a), 32'h1);
        wait_e(1);
        cfg_valid_a = 1'b0;
        #1 check("wr1_pending", 32'(cfg_ready_a), 32'h0);
        wait_e(1);  check("e15_pending", 32'(cfg_ready_a), 32'h0);
        wait_e(1);  check("e16_ready", 32'(cfg_ready_a), 32'h1);
                    check("e16_clk_out", 32'(clk_out_a), 32'h0);
        wait_e(2);  check("e18_clk_out", 32'(clk_out_a), 32'h1);

        // Back-to-back writes div=5 then div=0 on ch0.
        cfg_valid_a = 1'b1; cfg_div_a = 8'd5;
        wait_e(1);
        cfg_div_a = 8'd0;
        #1 check("b2b_stall", 32'(cfg_ready_a), 32'h0);
        k = 0;
        while (!cfg_ready_a && k < 40) begin
            wait_e(1);
            k++;
        end
        check("b2b_stall_cycles", 32'(k), 32'd1);
        wait_e(1);
        cfg_valid_a = 1'b0;
        #1 check("b2b_second_pending", 32'(cfg_ready_a), 32'h0);
        wait_e(4);  check("b2b_still_pending", 32'(cfg_ready_a), 32'h0);
        wait_e(1);  check("b2b_div0_applied", 32'(cfg_ready_a), 32'h1);
                    check("b2b_tick0_a", 32'(tick_a[0]), tk(32'h1));
        for (int i = 0; i < 3; i++) begin
            wait_e(1);
            check("div0_tick_high", 32'(tick_a[0]), tk(32'h1));
        end

        // Disable ch1 at cnt=2, then write div=7 while disabled.
        k = 0;
        while (m_left[1] != 2 && k < 20) begin
            wait_e(1);
            k++;
        end
        check("find_cnt2", 32'(m_left[1]), 32'd2);
        en_a = 2'b01;
        sv_clk1 = m_clk[1];
        wait_e(10);
        check("dis_hold_clk1", 32'(clk_out_a[1]), 32'(sv_clk1));
        check("dis_tick1", 32'(tick_a[1]), 32'h0);
        cfg_valid_a = 1'b1; cfg_ch_a = 1'b1; cfg_div_a = 8'd7;
        #1 check("dis_wr_ready", 32'(cfg_ready_a), 32'h1);
        wait_e(1);
        cfg_valid_a = 1'b0;
        #1 check("dis_wr_pending", 32'(cfg_ready_a), 32'h0);
        wait_e(1);  check("dis_wr_applied", 32'(cfg_ready_a), 32'h1);
        en_a = 2'b11;
        wait_e(7);  check("reen_e7_clk1", 32'(clk_out_a[1]), 32'(sv_clk1));
                    check("reen_e7_tick1", 32'(tick_a[1]), 32'h0);
        wait_e(1);  check("reen_e8_clk1", 32'(clk_out_a[1]), 32'(!sv_clk1));
                    check("reen_e8_tick1", 32'(tick_a[1]), tk(32'h1));

        // Write to nonexistent channel 3 on the 3-channel instance.
        cfg_valid_b = 1'b1; cfg_ch_b = 2'd3; cfg_div_b = 8'd9;
        #1 check("oor_ready", 32'(cfg_ready_b), 32'h1);
        wait_e(1);
        cfg_valid_b = 1'b0;
        #1 check("oor_after_ready", 32'(cfg_ready_b), 32'h1);
        wait_e(12);

        // Reset with a write pending on ch0.
        cfg_valid_a = 1'b1; cfg_ch_a = 1'b0; cfg_div_a = 8'd2;
        #1 check("prerst_ready", 32'(cfg_ready_a), 32'h1);
        wait_e(1);
        cfg_valid_a = 1'b0; rst = 1'b1;
        #1 check("prerst_pending", 32'(cfg_ready_a), 32'h0);
        wait_e(1);
        check("rst2_clk_out", 32'(clk_out_a), 32'h0);
        check("rst2_tick", 32'(tick_a), 32'h0);
        check("rst2_ready", 32'(cfg_ready_a), 32'h1);
        check("rst2_clk_out_b", 32'(clk_out_b), 32'h0);
        rst = 1'b0;
        wait_e(3);  check("r2_e3_clk_out", 32'(clk_out_a), 32'h0);
        wait_e(1);  check("r2_e4_clk_out", 32'(clk_out_a), 32'h3);
                    check("r2_e4_tick", 32'(tick_a), tk(32'h3));
        wait_e(3);  check("r2_e7_clk_out", 32'(clk_out_a), 32'h3);
        wait_e(1);  check("r2_e8_clk_out", 32'(clk_out_a), 32'h0);
        wait_e(4);  check("r2_e12_clk_out", 32'(clk_out_a), 32'h3);

        wait_e(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
